// File: rtl/wisc_pkg.sv
// Shared pipeline-control types: hazard FSM states and the hard-wired zero register.
package wisc_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } hz_state_t;

  localparam logic [3:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 0xFFFF; a synchronous clear wins over an increment.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    if (clr) begin
      count_d = 16'd0;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect squashes and HLT, plus
// saturating stall/flush performance counters.
module hazard_ctrl
  import wisc_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_hlt,
  input  logic        ex_mem_to_reg,
  input  logic [3:0]  ex_reg_rd,
  input  logic        ex_redirect,
  input  logic        cnt_clr,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [1:0] BUB_LOAD = 2'(REDIRECT_BUBBLES - 1);

  hz_state_t  state_q, state_d;
  logic [1:0] bub_q, bub_d;
  logic       lu;
  logic       stall_inc;

  assign lu = ex_mem_to_reg && (ex_reg_rd != REG_ZERO) &&
              ((id_uses_rs1 && (id_rs1 == ex_reg_rd)) ||
               (id_uses_rs2 && (id_rs2 == ex_reg_rd)));

  always_comb begin
    state_d    = state_q;
    bub_d      = bub_q;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    stall_inc  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (REDIRECT_BUBBLES > 1) begin
            bub_d   = BUB_LOAD;
            state_d = FLUSH;
          end
        end else if (lu) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else if (id_hlt) begin
          // Outputs stay low so the HLT itself moves into ID/EX.
          state_d = HALT;
        end
      end
      FLUSH: begin
        // Wrong-path or bubble instructions: redirect, lu and hlt are ignored.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        bub_d      = bub_q - 2'd1;
        if (bub_q == 2'd1) begin
          state_d = RUN;
        end
      end
      HALT: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        halted     = 1'b1;
      end
      default: state_d = RUN;
    endcase
    // Outputs are forced low for the whole time reset is held.
    if (!rst_n) begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      halted     = 1'b0;
      stall_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      bub_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (ifid_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; three instances (REDIRECT_BUBBLES = 1, 2, 3) share stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_rs1, id_rs2, ex_reg_rd;
  logic       id_uses_rs1, id_uses_rs2, id_hlt, ex_mem_to_reg, ex_redirect, cnt_clr;

  logic [2:0]  pc_stall, ifid_stall, ifid_flush, idex_flush, halted;
  logic [15:0] stall_cnt [3];
  logic [15:0] flush_cnt [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(.REDIRECT_BUBBLES(g + 1)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_uses_rs1   (id_uses_rs1),
      .id_uses_rs2   (id_uses_rs2),
      .id_hlt        (id_hlt),
      .ex_mem_to_reg (ex_mem_to_reg),
      .ex_reg_rd     (ex_reg_rd),
      .ex_redirect   (ex_redirect),
      .cnt_clr       (cnt_clr),
      .pc_stall      (pc_stall[g]),
      .ifid_stall    (ifid_stall[g]),
      .ifid_flush    (ifid_flush[g]),
      .idex_flush    (idex_flush[g]),
      .halted        (halted[g]),
      .stall_cnt     (stall_cnt[g]),
      .flush_cnt     (flush_cnt[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {pc_stall, ifid_stall, ifid_flush, idex_flush, halted} for instance i.
  function automatic logic [4:0] outs(input int i);
    return {pc_stall[i], ifid_stall[i], ifid_flush[i], idex_flush[i], halted[i]};
  endfunction

  task automatic idle();
    id_rs1 = 4'd0; id_rs2 = 4'd0; ex_reg_rd = 4'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_hlt = 1'b0;
    ex_mem_to_reg = 1'b0; ex_redirect = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic set_lu();
    ex_mem_to_reg = 1'b1; ex_reg_rd = 4'd5; id_rs2 = 4'd5; id_uses_rs2 = 1'b1;
  endtask

  // Advance one clock: inputs change on the falling edge, outputs are sampled 1 unit later.
  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    // Reset with hazard-provoking inputs: everything must stay low.
    set_lu(); id_hlt = 1'b1;
    next(); #1;
    check("reset_outs", 32'(outs(1)), 32'b00000);
    check("reset_stall_cnt", 32'(stall_cnt[1]), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt[1]), 32'd0);
    idle();
    next(); rst_n = 1'b1;

    // Load-use: one cycle of lu then a bubble in EX.
    next(); set_lu(); #1;
    check("lu_outs", 32'(outs(1)), 32'b11010);
    next(); ex_mem_to_reg = 1'b0; #1;
    check("lu_bubble_outs", 32'(outs(1)), 32'b00000);
    check("lu_stall_cnt", 32'(stall_cnt[1]), 32'd1);
    next(); idle(); #1;
    check("lu_stall_cnt_hold", 32'(stall_cnt[1]), 32'd1);

    // R0 destination and unused operand.
    ex_mem_to_reg = 1'b1; ex_reg_rd = 4'd0; id_rs1 = 4'd0; id_uses_rs1 = 1'b1; #1;
    check("r0_no_stall", 32'(pc_stall[1]), 32'd0);
    next(); ex_reg_rd = 4'd3; id_rs1 = 4'd3; id_uses_rs1 = 1'b0; #1;
    check("unused_no_stall", 32'(pc_stall[1]), 32'd0);
    next(); idle(); #1;
    check("no_stall_cnt", 32'(stall_cnt[1]), 32'd1);

    // Redirect together with lu; lu held on through the flush window.
    next(); set_lu(); ex_redirect = 1'b1; #1;
    for (int i = 0; i < 3; i++) check($sformatf("redir_c1_b%0d", i + 1), 32'(outs(i)), 32'b00110);
    next(); ex_redirect = 1'b0; #1;
    check("redir_c2_b1", 32'(outs(0)), 32'b11010);
    check("redir_c2_b2", 32'(outs(1)), 32'b00110);
    check("redir_c2_b3", 32'(outs(2)), 32'b00110);
    next(); #1;
    check("redir_c3_b2", 32'(outs(1)), 32'b11010);
    check("redir_c3_b3", 32'(outs(2)), 32'b00110);
    check("redir_c3_b2_stall_cnt", 32'(stall_cnt[1]), 32'd1);
    next(); idle(); #1;
    check("redir_c4_b3", 32'(outs(2)), 32'b00000);
    check("redir_flush_cnt_b1", 32'(flush_cnt[0]), 32'd1);
    check("redir_flush_cnt_b2", 32'(flush_cnt[1]), 32'd2);
    check("redir_flush_cnt_b3", 32'(flush_cnt[2]), 32'd3);
    check("redir_stall_cnt_b1", 32'(stall_cnt[0]), 32'd3);
    check("redir_stall_cnt_b2", 32'(stall_cnt[1]), 32'd2);
    check("redir_stall_cnt_b3", 32'(stall_cnt[2]), 32'd1);

    // Reset in the first FLUSH cycle.
    next(); ex_redirect = 1'b1;
    next(); ex_redirect = 1'b0; #1;
    check("midflush_pre", 32'(outs(1)), 32'b00110);
    rst_n = 1'b0; #1;
    check("midflush_reset_outs", 32'(outs(1)), 32'b00000);
    check("midflush_reset_flush_cnt", 32'(flush_cnt[1]), 32'd0);
    next(); rst_n = 1'b1; #1;
    check("midflush_release", 32'(outs(1)), 32'b00000);
    next(); set_lu(); #1;
    check("midflush_run_rules", 32'(outs(1)), 32'b11010);
    next(); idle();

    // Halt, then an ignored redirect, then reset.
    next(); id_hlt = 1'b1; #1;
    check("hlt_cycle_outs", 32'(outs(1)), 32'b00000);
    next(); id_hlt = 1'b0; #1;
    check("halted_outs", 32'(outs(1)), 32'b11011);
    next(); ex_redirect = 1'b1; #1;
    check("halted_ignore_redir", 32'(outs(1)), 32'b11011);
    next(); #1;
    check("halted_stays", 32'(halted[1]), 32'd1);
    rst_n = 1'b0; #1;
    check("halt_reset", 32'(halted[1]), 32'd0);
    next(); idle(); rst_n = 1'b1;

    // Saturation: 65540 load-use edges from a cleared counter.
    next(); set_lu();
    for (int i = 0; i < 65540; i++) next();
    #1;
    check("sat_stall_cnt", 32'(stall_cnt[1]), 32'hFFFF);
    cnt_clr = 1'b1;
    next(); #1;
    check("clr_stall_cnt", 32'(stall_cnt[1]), 32'd0);
    check("clr_flush_cnt", 32'(flush_cnt[1]), 32'd0);
    cnt_clr = 1'b0;
    next(); #1;
    check("post_clr_stall_cnt", 32'(stall_cnt[1]), 32'd1);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
